// File: rtl/stream_fifo_channel.sv
// Stream channel between a producer kernel (put_*) and a consumer kernel (get_*), buffered in a DEPTH-entry FIFO.
// Optional occupancy/stall statistics ports are built when STREAM_FIFO_STATS_EN is defined.
module stream_fifo_channel #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             put_en,
    input  logic [WIDTH-1:0] put_val_arg,
    output logic             put_done,
    output logic             put_dummy_ret_ret,
    input  logic             get_en,
    output logic             get_done,
    output logic [WIDTH-1:0] get_val_ret,
`ifdef STREAM_FIFO_STATS_EN
    output logic [AW:0]      max_level,
    output logic [31:0]      put_stalls,
`endif
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_next;
    logic             empty;
    logic             full;
    logic             put_xfer;
    logic             get_xfer;

    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);

    // rst and clear block both handshakes so no word moves in a flush cycle.
    always_comb begin
        get_xfer = 1'b0;
        put_xfer = 1'b0;
        if (!rst && !clear) begin
            get_xfer = get_en && !empty;
            put_xfer = put_en && (!full || get_xfer);
        end
    end

    assign get_done          = get_xfer;
    assign put_done          = put_xfer;
    assign put_dummy_ret_ret = 1'b0;
    assign get_val_ret       = (!rst && !empty) ? mem[rd_ptr] : '0;

    always_comb begin
        level_next = level;
        case ({put_xfer, get_xfer})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (put_xfer) wr_ptr <= wr_ptr + 1'b1;
            if (get_xfer) rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
        end
    end

    always_ff @(posedge clk) begin
        if (put_xfer) mem[wr_ptr] <= put_val_arg;
    end

`ifdef STREAM_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            max_level  <= '0;
            put_stalls <= '0;
        end else begin
            if (level_next > max_level) max_level <= level_next;
            if (put_en && !put_xfer && (put_stalls != '1)) put_stalls <= put_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo_channel.sv
// Scoreboard bench for stream_fifo_channel: stimulus queues expected words, a negedge monitor checks every get.
// Build with STREAM_FIFO_STATS_EN defined to also exercise the statistics ports.
module tb_stream_fifo_channel;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             put_en;
    logic [WIDTH-1:0] put_val_arg;
    logic             put_done;
    logic             put_dummy_ret_ret;
    logic             get_en;
    logic             get_done;
    logic [WIDTH-1:0] get_val_ret;
    logic [AW:0]      level;
`ifdef STREAM_FIFO_STATS_EN
    logic [AW:0]      max_level;
    logic [31:0]      put_stalls;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q [$];

    always #5 clk = ~clk;

    stream_fifo_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .clear             (clear),
        .put_en            (put_en),
        .put_val_arg       (put_val_arg),
        .put_done          (put_done),
        .put_dummy_ret_ret (put_dummy_ret_ret),
        .get_en            (get_en),
        .get_done          (get_done),
        .get_val_ret       (get_val_ret),
`ifdef STREAM_FIFO_STATS_EN
        .max_level         (max_level),
        .put_stalls        (put_stalls),
`endif
        .level             (level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Monitor: every completed get must deliver the oldest outstanding expected word.
    always @(negedge clk) begin
        if (!rst && get_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL get_unexpected: got 0x%0h with no word expected at %0t", get_val_ret, $time);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (get_val_ret !== e) begin
                    errors++;
                    $display("FAIL get_data: got 0x%0h expected 0x%0h at %0t", get_val_ret, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int cyc;
        int max_seen;

        rst = 1'b1; clear = 1'b0;
        put_en = 1'b1; put_val_arg = 32'h55; get_en = 1'b1;
        #1;

        // Reset held 3 cycles with requests pending.
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_put_done", 32'(put_done), 32'd0);
            chk("rst_get_done", 32'(get_done), 32'd0);
            chk("rst_get_val", get_val_ret, 32'd0);
            tick();
            chk("rst_level", 32'(level), 32'd0);
        end
        rst = 1'b0; put_en = 1'b0; get_en = 1'b0;
        settle();
        chk("dummy_ret", 32'(put_dummy_ret_ret), 32'd0);
        chk("idle_get_val", get_val_ret, 32'd0);
        tick();

        // Ordering: three puts, then three consecutive gets.
        for (int i = 0; i < 3; i++) begin
            put_en = 1'b1;
            put_val_arg = 32'h11 * (i + 1);
            settle();
            chk("order_put_done", 32'(put_done), 32'd1);
            exp_q.push_back(32'h11 * (i + 1));
            tick();
        end
        put_en = 1'b0;
        chk("order_level3", 32'(level), 32'd3);
        get_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("order_get_done", 32'(get_done), 32'd1);
            tick();
            chk("order_level", 32'(level), 32'(2 - i));
        end
        settle();
        chk("order_empty_get_done", 32'(get_done), 32'd0);
        tick();
        get_en = 1'b0;

        // Full: fifth put stalls until a get completes in the same cycle.
        for (int i = 0; i < 4; i++) begin
            put_en = 1'b1;
            put_val_arg = 32'hA0 + i;
            settle();
            chk("full_put_done", 32'(put_done), 32'd1);
            exp_q.push_back(32'hA0 + i);
            tick();
        end
        put_val_arg = 32'hA4;
        settle();
        chk("full_put_stall", 32'(put_done), 32'd0);
        chk("full_level4", 32'(level), 32'd4);
        tick();
        get_en = 1'b1;
        settle();
        chk("full_put_with_get", 32'(put_done), 32'd1);
        chk("full_get_done", 32'(get_done), 32'd1);
        exp_q.push_back(32'hA4);
        tick();
        chk("full_level_hold", 32'(level), 32'd4);
`ifdef STREAM_FIFO_STATS_EN
        chk("stats_max_level", 32'(max_level), 32'd4);
        chk("stats_put_stalls", put_stalls, 32'd1);
`endif
        put_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("full_drained", 32'(level), 32'd0);
        get_en = 1'b0;

        // Empty: no fall-through, word visible one cycle after its write edge.
        get_en = 1'b1; put_en = 1'b1; put_val_arg = 32'hAB;
        settle();
        chk("empty_get_done", 32'(get_done), 32'd0);
        chk("empty_put_done", 32'(put_done), 32'd1);
        exp_q.push_back(32'hAB);
        tick();
        put_en = 1'b0;
        settle();
        chk("empty_next_get_done", 32'(get_done), 32'd1);
        chk("empty_next_val", get_val_ret, 32'hAB);
        tick();
        get_en = 1'b0;
        chk("empty_level", 32'(level), 32'd0);

        // Wrap: 20 words, put always requested, get every other cycle.
        p = 0; cyc = 0; max_seen = 0;
        while (p < 20 && cyc < 200) begin
            put_en = 1'b1;
            put_val_arg = 32'(p);
            get_en = cyc[0];
            settle();
            if (put_done) begin
                exp_q.push_back(32'(p));
                p++;
            end
            tick();
            if (int'(level) > max_seen) max_seen = int'(level);
            cyc++;
        end
        chk("wrap_all_put", 32'(p), 32'd20);
        put_en = 1'b0; get_en = 1'b1;
        cyc = 0;
        while (level != '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        get_en = 1'b0;
        chk("wrap_drained", 32'(level), 32'd0);
        chk("wrap_max_level", 32'(max_seen), 32'd4);
        chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Clear: three buffered words are discarded, pending requests complete later.
        for (int i = 0; i < 3; i++) begin
            put_en = 1'b1;
            put_val_arg = 32'hC1 + i;
            tick();
        end
        chk("clear_level3", 32'(level), 32'd3);
        clear = 1'b1; put_val_arg = 32'hC4; get_en = 1'b1;
        settle();
        chk("clear_put_done", 32'(put_done), 32'd0);
        chk("clear_get_done", 32'(get_done), 32'd0);
        tick();
        clear = 1'b0;
        chk("clear_level0", 32'(level), 32'd0);
`ifdef STREAM_FIFO_STATS_EN
        chk("clear_max_level", 32'(max_level), 32'd0);
        chk("clear_put_stalls", put_stalls, 32'd0);
`endif
        settle();
        chk("after_clear_put_done", 32'(put_done), 32'd1);
        chk("after_clear_get_done", 32'(get_done), 32'd0);
        exp_q.push_back(32'hC4);
        tick();
        put_en = 1'b0;
        settle();
        chk("after_clear_get", 32'(get_done), 32'd1);
        tick();
        get_en = 1'b0;
        chk("final_level", 32'(level), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
